// File: rtl/instr_mem_loader.sv
// Streams bytes from a source into 32-bit instruction words (MSB-first) and
// writes DEPTH consecutive words to instruction memory per start pulse.
module instr_mem_loader #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t           state;
  logic [1:0]       byte_cnt;
  logic [IDX_W-1:0] word_idx;
  // First three bytes of the word in flight; the fourth is merged on the write.
  logic [23:0]      word_sr;

  // Session FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_cnt   <= 2'd0;
      word_idx   <= '0;
      word_sr    <= 24'd0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= 32'd0;
      wr_data    <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            byte_cnt   <= 2'd0;
            word_idx   <= '0;
            word_count <= '0;
          end
        end
        LOAD: begin
          if (byte_valid) begin
            if (byte_cnt == 2'd3) begin
              state      <= WRITE;
              byte_ready <= 1'b0;
              wr_en      <= 1'b1;
              wr_addr    <= 32'(word_idx);
              wr_data    <= {word_sr, byte_data};
              byte_cnt   <= 2'd0;
            end else begin
              word_sr  <= {word_sr[15:0], byte_data};
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        WRITE: begin
          word_count <= word_count + CNT_W'(1);
          if (word_idx == IDX_W'(DEPTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= LOAD;
            word_idx   <= word_idx + IDX_W'(1);
            byte_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: table of 16 words streamed in several
// session scenarios, with writes captured by a monitor and compared per word.
module tb_instr_mem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [4:0]  word_count;

  instr_mem_loader #(.DEPTH(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  typedef struct packed {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vecs [16];
  logic [31:0] wq_addr [$];
  logic [31:0] wq_data [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          t0 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Capture every write strobe; a strobe must only appear while busy and not ready.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      chk("wr_strobe_ctx", {29'd0, byte_ready, busy, done}, 32'd2);
    end
  end

  function automatic logic [7:0] byte_of(input int i, input int j);
    case (j)
      0:       return vecs[i].b0;
      1:       return vecs[i].b1;
      2:       return vecs[i].b2;
      default: return vecs[i].b3;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int k = 0; k < 40 && !ok; k++) begin
      ok = byte_ready;
      @(posedge clk);
      @(negedge clk);
    end
    chk("byte_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic run_session(input bit throttle, input int start_word, input int n_bytes);
    int sent;
    sent = 0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (sent < n_bytes) begin
          if (i == start_word && j == 0) start = 1'b1;
          send_byte(byte_of(i, j));
          start = 1'b0;
          sent++;
          if (throttle) begin
            byte_valid = 1'b0;
            if (j < 3) chk("ready_in_load", {31'd0, byte_ready}, 32'd1);
            @(negedge clk);
          end
        end
      end
    end
    byte_valid = 1'b0;
    if (n_bytes == 64) begin
      for (int k = 0; k < 50 && !done; k++) @(negedge clk);
      chk("done_set", {31'd0, done}, 32'd1);
    end
  endtask

  task automatic check_writes(input int n);
    chk("write_count", 32'(wq_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      chk($sformatf("wr_addr[%0d]", i), wq_addr[i], 32'(i));
      chk($sformatf("wr_data[%0d]", i), wq_data[i], vecs[i].exp_data);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    chk({tag, "_wr_addr"}, wr_addr, 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_word_count"}, {27'd0, word_count}, 32'd0);
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{8'h20, 8'h08, 8'h00, 8'h05, 32'h20080005};
    vecs[1]  = '{8'h20, 8'h09, 8'h00, 8'h0A, 32'h2009000A};
    vecs[2]  = '{8'h01, 8'h09, 8'h50, 8'h20, 32'h01095020};
    vecs[3]  = '{8'hAC, 8'h0A, 8'h00, 8'h00, 32'hAC0A0000};
    vecs[4]  = '{8'h8C, 8'h0B, 8'h00, 8'h00, 32'h8C0B0000};
    vecs[5]  = '{8'h11, 8'h6A, 8'h00, 8'h02, 32'h116A0002};
    vecs[6]  = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
    vecs[7]  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
    vecs[8]  = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h12345678};
    vecs[9]  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hDEADBEEF};
    vecs[10] = '{8'h80, 8'h00, 8'h00, 8'h01, 32'h80000001};
    vecs[11] = '{8'h01, 8'h80, 8'h00, 8'h00, 32'h01800000};
    vecs[12] = '{8'hA5, 8'h5A, 8'hA5, 8'h5A, 32'hA55AA55A};
    vecs[13] = '{8'h3C, 8'h01, 8'h10, 8'h01, 32'h3C011001};
    vecs[14] = '{8'h08, 8'h00, 8'h00, 8'h00, 32'h08000000};
    vecs[15] = '{8'h00, 8'h00, 8'h00, 8'h0C, 32'h0000000C};

    rst_n = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Stray bytes in IDLE are neither accepted nor start anything.
    byte_valid = 1'b1;
    byte_data  = 8'hEE;
    repeat (3) begin
      @(negedge clk);
      chk("idle_stray_ready", {31'd0, byte_ready}, 32'd0);
      chk("idle_stray_busy", {31'd0, busy}, 32'd0);
    end
    byte_valid = 1'b0;

    // Continuous full load.
    clear_q();
    pulse_start();
    run_session(1'b0, -1, 64);
    chk("full_cycles", 32'(cyc - t0), 32'd80);
    check_writes(16);
    chk("full_word_count", {27'd0, word_count}, 32'd16);
    chk("full_busy", {31'd0, busy}, 32'd0);

    // Stray bytes in DONE; outputs hold and no write appears.
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk("done_stray_ready", {31'd0, byte_ready}, 32'd0);
      chk("done_stray_done", {31'd0, done}, 32'd1);
      chk("done_hold_addr", wr_addr, 32'd15);
      chk("done_hold_data", wr_data, 32'h0000000C);
    end
    byte_valid = 1'b0;
    chk("done_stray_writes", 32'(wq_addr.size()), 32'd16);

    // Restart from DONE, then a throttled load.
    clear_q();
    pulse_start();
    chk("restart_done", {31'd0, done}, 32'd0);
    chk("restart_word_count", {27'd0, word_count}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    chk("restart_ready", {31'd0, byte_ready}, 32'd1);
    run_session(1'b1, -1, 64);
    check_writes(16);
    chk("throttle_word_count", {27'd0, word_count}, 32'd16);

    // start held across WRITE and LOAD after two words must be ignored.
    clear_q();
    pulse_start();
    run_session(1'b0, 2, 64);
    check_writes(16);
    chk("illegal_word_count", {27'd0, word_count}, 32'd16);

    // Reset after two bytes of word 5, asserted between clock edges.
    clear_q();
    pulse_start();
    run_session(1'b0, -1, 22);
    chk("pre_reset_writes", 32'(wq_addr.size()), 32'd5);
    chk("pre_reset_count", {27'd0, word_count}, 32'd5);
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_writes", 32'(wq_addr.size()), 32'd5);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    chk("post_reset_ready", {31'd0, byte_ready}, 32'd0);
    clear_q();
    pulse_start();
    run_session(1'b0, -1, 64);
    check_writes(16);
    chk("reload_word_count", {27'd0, word_count}, 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter DEPTH, default 16, number of 32-bit instruction words loaded per session.
REQ-002 Parameter CNT_W, default 5, width of word_count, sufficient to hold DEPTH.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 byte_valid  input  1  source presents a byte on byte_data.
REQ-007 byte_data  input  8  instruction byte, MSB-first within each word.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 wr_en  output  1  one-cycle write strobe to instruction memory.
REQ-010 wr_addr  output  32  word index being written, 0 to DEPTH-1, same indexing as the memory's instr_addr.
REQ-011 wr_data  output  32  assembled instruction word.
REQ-012 busy  output  1  session in progress.
REQ-013 done  output  1  all DEPTH words written; held until the next start.
REQ-014 word_count  output  CNT_W  number of words written in the current or last session.

Function
REQ-015 FSM states IDLE, LOAD, WRITE, DONE; reset state IDLE.
REQ-016 IDLE: byte_ready=0, busy=0; start=1 -> LOAD with byte counter=0, word index=0, word_count=0.
REQ-017 LOAD: byte_ready=1, busy=1; a byte transfers only when byte_valid=1 and byte_ready=1 at the same rising edge.
REQ-018 Byte packing: wr_data shifts left 8 and takes byte_data in [7:0]; the 1st byte of a word ends in [31:24] and the 4th in [7:0].
REQ-019 byte_valid=0 in LOAD: hold state, byte counter and partial word; there is no timeout.
REQ-020 Transfer of the 4th byte -> WRITE on the next edge; byte counter returns to 0.
REQ-021 WRITE lasts exactly 1 cycle: wr_en=1, byte_ready=0, busy=1, wr_addr=current word index, wr_data=assembled word.
REQ-022 Leaving WRITE: word_count increments by 1; if word index = DEPTH-1 -> DONE, else word index increments and state -> LOAD.
REQ-023 Write latency is 1 cycle after the 4th-byte handshake; peak throughput is 1 word per 5 cycles.
REQ-024 DONE: done=1, busy=0, byte_ready=0, wr_en=0; word_count holds DEPTH.
REQ-025 start=1 in DONE or IDLE restarts the session: done clears on the next edge and state -> LOAD with all counters 0.
REQ-026 start is ignored in LOAD and WRITE; a session cannot be restarted mid-load.
REQ-027 byte_valid=1 outside LOAD is ignored; no byte is consumed.
REQ-028 wr_en is never asserted outside WRITE; wr_addr and wr_data hold their last values when wr_en=0.
REQ-029 The word index never exceeds DEPTH-1; there is no wrap-around within a session.

Reset
REQ-030 rst_n=0 forces the following immediately, independent of clk: state=IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, word_count=0, byte counter=0.
REQ-031 Reset asserted mid-session abandons any partial word; no write strobe is emitted.
REQ-032 After rst_n deasserts, the loader waits in IDLE for start.

Verification
REQ-033 Full load: start, then 64 bytes streamed continuously. Required response:
- 16 wr_en pulses.
- wr_addr 0..15 in order.
- Word 0 bytes 8'h20,8'h08,8'h00,8'h05 -> wr_data 32'h20080005.
- done=1, word_count=16.
- 80 cycles from first byte to DONE.
REQ-034 Throttled source: byte_valid toggles every other cycle. Required response: identical written data and addresses to the full load; byte_ready stays 1 in LOAD; no extra or lost bytes.
REQ-035 Illegal start: start pulsed while busy after 2 words. Required response: ignored; session completes with 16 writes and word_count=16.
REQ-036 Mid-word reset: rst_n=0 after 2 bytes of word 5. Required response:
- All outputs 0 asynchronously.
- No wr_en for word 5.
- A new start reloads from wr_addr 0.
REQ-037 Restart from DONE: start in DONE. Required response: done drops next cycle, word_count=0, and the first write of the new session is to wr_addr 0.
REQ-038 Stray input: byte_valid=1 in IDLE and DONE. Required response: byte_ready=0 and no state change.
